ctrl_req_queue: RTL

//  Host-side request queue directly upstream of the DDR4 controller FSM / ACT-CAS stages.

---
 rtl/ctrl_req_queue.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ctrl_req_queue.sv
// In-order host request queue feeding the DDR4 command FSM. It splits addresses into
// row/bg/ba/col, registers the head command and tracks the open row of every bank for hit detection.
module ctrl_req_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int COL_W  = 10,
    parameter int BA_W   = 2,
    parameter int BG_W   = 2,
    parameter int ROW_W  = 17,
    localparam int ADDR_W = ROW_W + BG_W + BA_W + COL_W,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CK_t,
    input  logic              reset_n,
    input  logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rw,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [COL_W-1:0]  cmd_col,
    output logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_row_hit,
    input  logic              prech_all,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int BK_W  = BG_W + BA_W;
    localparam int NBANK = 1 << BK_W;

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_mem_rw    [DEPTH];
    logic [ADDR_W-1:0] r_mem_addr  [DEPTH];
    logic [DATA_W-1:0] r_mem_wdata [DEPTH];
    logic              r_cmd_rw;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [DATA_W-1:0] r_cmd_wdata;
    logic [NBANK-1:0]  r_open_vld;
    logic [ROW_W-1:0]  r_open_row  [NBANK];

    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_wdata_in;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_head_byp;
    logic [BK_W-1:0]   w_bank_idx;

    assign req_ready    = (r_count < CNT_W'(DEPTH));
    assign cmd_valid    = (r_count != {CNT_W{1'b0}}) & init_done;
    assign w_push       = req_valid & req_ready;
    assign w_pop        = cmd_valid & cmd_ready;
    assign w_wdata_in   = req_rw ? {DATA_W{1'b0}} : req_wdata;
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
    // The entry written this cycle becomes the head when it lands exactly at the next read slot.
    assign w_head_byp   = w_push & (w_rd_ptr_nxt == r_wr_ptr);

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign cmd_rw    = r_cmd_rw;
    assign cmd_col   = r_cmd_addr[COL_W-1:0];
    assign cmd_ba    = r_cmd_addr[COL_W +: BA_W];
    assign cmd_bg    = r_cmd_addr[COL_W+BA_W +: BG_W];
    assign cmd_row   = r_cmd_addr[ADDR_W-1 -: ROW_W];
    assign cmd_wdata = r_cmd_wdata;

    assign w_bank_idx  = {cmd_bg, cmd_ba};
    assign cmd_row_hit = cmd_valid & r_open_vld[w_bank_idx] & (r_open_row[w_bank_idx] == cmd_row);

    // Next occupancy from the push/pop combination.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Queue storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_count    <= {CNT_W{1'b0}};
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_rw[i]    <= 1'b0;
                r_mem_addr[i]  <= {ADDR_W{1'b0}};
                r_mem_wdata[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem_rw[r_wr_ptr]    <= req_rw;
                r_mem_addr[r_wr_ptr]  <= req_addr;
                r_mem_wdata[r_wr_ptr] <= w_wdata_in;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= r_overflow | (req_valid & ~req_ready);
        end
    end

    // Registered head stage; holds its last contents once the queue drains.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_rw    <= 1'b0;
            r_cmd_addr  <= {ADDR_W{1'b0}};
            r_cmd_wdata <= {DATA_W{1'b0}};
        end else if (w_count_nxt != {CNT_W{1'b0}}) begin
            if (w_head_byp) begin
                r_cmd_rw    <= req_rw;
                r_cmd_addr  <= req_addr;
                r_cmd_wdata <= w_wdata_in;
            end else begin
                r_cmd_rw    <= r_mem_rw[w_rd_ptr_nxt];
                r_cmd_addr  <= r_mem_addr[w_rd_ptr_nxt];
                r_cmd_wdata <= r_mem_wdata[w_rd_ptr_nxt];
            end
        end
    end

    // Open-row table; a precharge-all overrides a simultaneous pop.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            r_open_vld <= {NBANK{1'b0}};
            for (int b = 0; b < NBANK; b++) begin
                r_open_row[b] <= {ROW_W{1'b0}};
            end
        end else if (prech_all) begin
            r_open_vld <= {NBANK{1'b0}};
        end else if (w_pop) begin
            r_open_vld[w_bank_idx] <= 1'b1;
            r_open_row[w_bank_idx] <= cmd_row;
        end
    end

endmodule
